// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type constants for the HDMI data-island scheduler.
package hdmi_packet_pkg;

  typedef logic [7:0] packet_type_t;

  localparam packet_type_t PKT_NULL         = 8'h00;
  localparam packet_type_t PKT_ACR          = 8'h01;
  localparam packet_type_t PKT_AUDIO_SAMPLE = 8'h02;
  localparam packet_type_t PKT_AVI          = 8'h82;
  localparam packet_type_t PKT_AUDIO_INFO   = 8'h84;

  localparam int unsigned STAT_W = 16;

  // Saturating increment for the per-frame statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/packet_priority_pick.sv
// Lowest-set-bit encoder: lower index means higher frame-packet priority.
module packet_priority_pick
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [WIDTH-1:0] mask,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = |mask;
    index = '0;
    // Walk downward so the last hit, the lowest set bit, wins.
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Per-frame data-island packet scheduler (frame packets, audio, null).
// Optional per-frame statistics outputs enabled by HDMI_SCHED_STATS_EN.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned FRAME_PACKETS = 2,
  parameter logic [FRAME_PACKETS*8-1:0] FRAME_PACKET_TYPES = {PKT_AUDIO_INFO, PKT_ACR},
  parameter int unsigned REMAINING_WIDTH = 7,
  parameter int unsigned SAMPLES_PER_PACKET = 1,
  parameter int unsigned AUDIO_URGENT_LEVEL = 0
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       packet_enable,
  input  logic [FRAME_PACKETS-1:0]   resend_req,
  input  logic [REMAINING_WIDTH-1:0] audio_remaining,
  output logic [7:0]                 packet_type,
  output logic                       audio_pop,
  output logic [2:0]                 sample_count,
  output logic [FRAME_PACKETS-1:0]   pending
`ifdef HDMI_SCHED_STATS_EN
  ,
  output logic [15:0]                null_count,
  output logic [15:0]                preempt_count
`endif
);

  localparam int unsigned IDX_W = (FRAME_PACKETS > 1) ? $clog2(FRAME_PACKETS) : 1;
  localparam int unsigned CMP_W = 32;

  packet_type_t              packet_type_q, packet_type_d;
  logic [2:0]                sample_count_q, sample_count_d;
  logic                      audio_pop_q, audio_pop_d;
  logic [FRAME_PACKETS-1:0]  pending_q, pending_d;

  logic [FRAME_PACKETS-1:0]  eff_mask_c;
  logic                      pick_valid_c;
  logic [IDX_W-1:0]          pick_index_c;
  packet_type_t              frame_type_c;
  logic                      urgent_c;
  logic                      has_audio_c;
  logic [2:0]                audio_samples_c;
  logic                      null_evt_c;
  logic                      preempt_evt_c;

  // Same-cycle set requests are visible to this cycle's selection.
  assign eff_mask_c  = pending_q | (frame_start ? {FRAME_PACKETS{1'b1}} : '0) | resend_req;
  assign has_audio_c = (audio_remaining != '0);
  assign urgent_c    = (AUDIO_URGENT_LEVEL != 0) &&
                       (CMP_W'(audio_remaining) >= CMP_W'(AUDIO_URGENT_LEVEL));

  packet_priority_pick #(
    .WIDTH (FRAME_PACKETS),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask  (eff_mask_c),
    .valid (pick_valid_c),
    .index (pick_index_c)
  );

  // Type of the highest-priority owed frame packet.
  always_comb begin
    frame_type_c = PKT_NULL;
    for (int unsigned i = 0; i < FRAME_PACKETS; i++) begin
      if (pick_index_c == IDX_W'(i)) begin
        frame_type_c = FRAME_PACKET_TYPES[i*8 +: 8];
      end
    end
  end

  // Samples per audio packet: min(remaining, SAMPLES_PER_PACKET) at buffer-count width.
  always_comb begin
    if (audio_remaining >= REMAINING_WIDTH'(SAMPLES_PER_PACKET)) begin
      audio_samples_c = 3'(SAMPLES_PER_PACKET);
    end else begin
      audio_samples_c = 3'(audio_remaining);
    end
  end

  // Slot decision: urgent audio, then frame packets, then audio, then null.
  always_comb begin
    packet_type_d  = packet_type_q;
    sample_count_d = sample_count_q;
    audio_pop_d    = 1'b0;
    pending_d      = eff_mask_c;
    null_evt_c     = 1'b0;
    preempt_evt_c  = 1'b0;

    if (packet_enable) begin
      if (urgent_c) begin
        packet_type_d  = PKT_AUDIO_SAMPLE;
        sample_count_d = audio_samples_c;
        audio_pop_d    = 1'b1;
        preempt_evt_c  = pick_valid_c;
      end else if (pick_valid_c) begin
        packet_type_d  = frame_type_c;
        sample_count_d = 3'd0;
        // Clearing the selected bit overrides any same-cycle set of it.
        pending_d      = eff_mask_c & ~(FRAME_PACKETS'(1) << pick_index_c);
      end else if (has_audio_c) begin
        packet_type_d  = PKT_AUDIO_SAMPLE;
        sample_count_d = audio_samples_c;
        audio_pop_d    = 1'b1;
      end else begin
        packet_type_d  = PKT_NULL;
        sample_count_d = 3'd0;
        null_evt_c     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      packet_type_q  <= PKT_NULL;
      sample_count_q <= 3'd0;
      audio_pop_q    <= 1'b0;
      pending_q      <= {FRAME_PACKETS{1'b1}};
    end else begin
      packet_type_q  <= packet_type_d;
      sample_count_q <= sample_count_d;
      audio_pop_q    <= audio_pop_d;
      pending_q      <= pending_d;
    end
  end

  assign packet_type  = packet_type_q;
  assign sample_count = sample_count_q;
  assign audio_pop    = audio_pop_q;
  assign pending      = pending_q;

`ifdef HDMI_SCHED_STATS_EN
  logic [STAT_W-1:0] null_run_q, null_run_d;
  logic [STAT_W-1:0] pre_run_q, pre_run_d;
  logic [STAT_W-1:0] null_out_q, null_out_d;
  logic [STAT_W-1:0] pre_out_q, pre_out_d;

  // A slot event coinciding with frame_start is attributed to the new frame.
  always_comb begin
    null_out_d = null_out_q;
    pre_out_d  = pre_out_q;
    null_run_d = sat_inc(null_run_q, null_evt_c);
    pre_run_d  = sat_inc(pre_run_q, preempt_evt_c);
    if (frame_start) begin
      null_out_d = null_run_q;
      pre_out_d  = pre_run_q;
      null_run_d = STAT_W'(null_evt_c);
      pre_run_d  = STAT_W'(preempt_evt_c);
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      null_run_q <= '0;
      pre_run_q  <= '0;
      null_out_q <= '0;
      pre_out_q  <= '0;
    end else begin
      null_run_q <= null_run_d;
      pre_run_q  <= pre_run_d;
      null_out_q <= null_out_d;
      pre_out_q  <= pre_out_d;
    end
  end

  assign null_count    = null_out_q;
  assign preempt_count = pre_out_q;
`endif

endmodule
